// File: rtl/rf_2p_be_wr_pack_if.sv
// rtl/rf_2p_be_wr_pack_if.sv - byte stream in / RF write port out bundle for rf_2p_be_wr_pack (wr_cnt_o present when PACK_WR_CNT_EN is defined)
interface rf_2p_be_wr_pack_if #(
    parameter int Word_Width = 32,
    parameter int Addr_Width = 8,
    parameter int Byte_Width = Word_Width >> 3
);

    // Frame control
    logic                  start_i;
    logic [Addr_Width-1:0] base_addr_i;
    logic                  done_o;

    // Byte stream
    logic                  byte_val_i;
    logic [7:0]            byte_dat_i;
    logic                  byte_last_i;
    logic                  byte_rdy_o;

    // Register-file B/write port (low-active enables)
    logic                  cenb_o;
    logic [Byte_Width-1:0] wenb_o;
    logic [Addr_Width-1:0] addrb_o;
    logic [Word_Width-1:0] datab_o;

`ifdef PACK_WR_CNT_EN
    logic [Addr_Width:0]   wr_cnt_o;
`endif

    // Packer side
    modport slave (
        input  start_i,
        input  base_addr_i,
        input  byte_val_i,
        input  byte_dat_i,
        input  byte_last_i,
        output byte_rdy_o,
        output done_o,
        output cenb_o,
        output wenb_o,
        output addrb_o,
`ifdef PACK_WR_CNT_EN
        output wr_cnt_o,
`endif
        output datab_o
    );

    // Byte producer / RF observer side
    modport master (
        output start_i,
        output base_addr_i,
        output byte_val_i,
        output byte_dat_i,
        output byte_last_i,
        input  byte_rdy_o,
        input  done_o,
        input  cenb_o,
        input  wenb_o,
        input  addrb_o,
`ifdef PACK_WR_CNT_EN
        input  wr_cnt_o,
`endif
        input  datab_o
    );

endinterface

// File: rtl/rf_2p_be_wr_pack.sv
// rtl/rf_2p_be_wr_pack.sv - packs an 8-bit byte stream little-endian into byte-enabled RF words; optional write counter under PACK_WR_CNT_EN
module rf_2p_be_wr_pack #(
    parameter int Word_Width = 32,
    parameter int Addr_Width = 8,
    parameter int Byte_Width = Word_Width >> 3
) (
    input  logic                  clk,
    input  logic                  rstn,
    rf_2p_be_wr_pack_if.slave     pack_if
);

    localparam int LaneW = (Byte_Width > 1) ? $clog2(Byte_Width) : 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PACK = 1'b1
    } state_t;

    // Accumulation side
    state_t                state_q;
    logic                  byte_rdy_q;
    logic [LaneW-1:0]      lane_q;
    logic [Byte_Width-1:0] mask_q;
    logic [Word_Width-1:0] acc_q;
    logic [Addr_Width-1:0] addr_q;

    // Write-out side, kept apart from the accumulator so the next word can
    // start filling while the previous one is on the RF port
    logic                  cenb_q;
    logic [Byte_Width-1:0] wenb_q;
    logic [Addr_Width-1:0] addrb_q;
    logic [Word_Width-1:0] datab_q;
    logic                  done_q;

`ifdef PACK_WR_CNT_EN
    logic [Addr_Width:0]   wr_cnt_q;
    localparam logic [Addr_Width:0] WrCntMax = {1'b1, {Addr_Width{1'b0}}};
`endif

    // A start pulse has priority over a byte in the same cycle, so the byte is
    // refused rather than silently lost
    logic byte_rdy;
    logic accept;
    assign byte_rdy = byte_rdy_q & ~pack_if.start_i;
    assign accept   = pack_if.byte_val_i & byte_rdy;

    // Word closes on the top lane or on the frame's last byte
    logic word_done;
    assign word_done = (lane_q == LaneW'(Byte_Width - 1)) | pack_if.byte_last_i;

    logic [Word_Width-1:0] acc_ins;
    logic [Byte_Width-1:0] mask_ins;
    logic [Word_Width-1:0] wr_data;

    // Merge the incoming byte into its lane and build the zero-filled write word
    always_comb begin
        acc_ins  = acc_q;
        mask_ins = mask_q;
        wr_data  = '0;
        for (int b = 0; b < Byte_Width; b++) begin
            if (lane_q == LaneW'(b)) begin
                acc_ins[b*8 +: 8] = pack_if.byte_dat_i;
                mask_ins[b]       = 1'b1;
            end
        end
        for (int b = 0; b < Byte_Width; b++) begin
            if (mask_ins[b]) begin
                wr_data[b*8 +: 8] = acc_ins[b*8 +: 8];
            end
        end
    end

    // Packer FSM: frame control, lane accumulation and the one-cycle write strobe
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            byte_rdy_q <= 1'b0;
            lane_q     <= '0;
            mask_q     <= '0;
            acc_q      <= '0;
            addr_q     <= '0;
            cenb_q     <= 1'b1;
            wenb_q     <= '1;
            addrb_q    <= '0;
            datab_q    <= '0;
            done_q     <= 1'b0;
`ifdef PACK_WR_CNT_EN
            wr_cnt_q   <= '0;
`endif
        end else begin
            // Strobes are single-cycle; address/data hold between writes
            cenb_q <= 1'b1;
            wenb_q <= '1;
            done_q <= 1'b0;

            if (pack_if.start_i) begin
                // New frame or abort: any partial word is dropped unwritten
                state_q    <= ST_PACK;
                byte_rdy_q <= 1'b1;
                addr_q     <= pack_if.base_addr_i;
                lane_q     <= '0;
                mask_q     <= '0;
                acc_q      <= '0;
`ifdef PACK_WR_CNT_EN
                wr_cnt_q   <= '0;
`endif
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        byte_rdy_q <= 1'b0;
                    end
                    ST_PACK: begin
                        if (accept) begin
                            if (word_done) begin
                                cenb_q  <= 1'b0;
                                wenb_q  <= ~mask_ins;
                                addrb_q <= addr_q;
                                datab_q <= wr_data;
                                addr_q  <= addr_q + Addr_Width'(1);
                                lane_q  <= '0;
                                mask_q  <= '0;
                                acc_q   <= '0;
`ifdef PACK_WR_CNT_EN
                                if (wr_cnt_q != WrCntMax) begin
                                    wr_cnt_q <= wr_cnt_q + (Addr_Width+1)'(1);
                                end
`endif
                                if (pack_if.byte_last_i) begin
                                    done_q     <= 1'b1;
                                    state_q    <= ST_IDLE;
                                    byte_rdy_q <= 1'b0;
                                end
                            end else begin
                                lane_q <= lane_q + LaneW'(1);
                                mask_q <= mask_ins;
                                acc_q  <= acc_ins;
                            end
                        end
                    end
                    default: begin
                        state_q    <= ST_IDLE;
                        byte_rdy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pack_if.byte_rdy_o = byte_rdy;
    assign pack_if.done_o     = done_q;
    assign pack_if.cenb_o     = cenb_q;
    assign pack_if.wenb_o     = wenb_q;
    assign pack_if.addrb_o    = addrb_q;
    assign pack_if.datab_o    = datab_q;
`ifdef PACK_WR_CNT_EN
    assign pack_if.wr_cnt_o   = wr_cnt_q;
`endif

endmodule
